// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: logic/arith ops in one cycle; shifts move one bit per cycle (FAST_SHIFT_EN selects a one-cycle barrel shifter).
// Latency: 1 cycle for non-shift ops, N+1 cycles for shifts by N>0 (1 cycle for every op with FAST_SHIFT_EN).
// Backpressure: the result is held in DONE until out_ready; in_ready is low in SHIFT and DONE, so inputs are ignored there.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         sel,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SLLV = 4'b1100;
    localparam logic [3:0] OP_SRLV = 4'b1101;
    localparam logic [3:0] OP_SRAV = 4'b1110;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;

    logic               w_var;
    logic [SHAMT_W-1:0] w_amt;
    logic [WIDTH-1:0]   w_alu_res;

    // Variable shifts take their amount from the low bits of rs.
    assign w_var = (sel == OP_SLLV) || (sel == OP_SRLV) || (sel == OP_SRAV);
    assign w_amt = w_var ? src_a[SHAMT_W-1:0] : shamt;

    always_comb begin
        w_alu_res = '0;
        case (sel)
            OP_AND:  w_alu_res = src_a & src_b;
            OP_OR:   w_alu_res = src_a | src_b;
            OP_ADD:  w_alu_res = src_a + src_b;
            OP_SUB:  w_alu_res = src_a - src_b;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_XOR:  w_alu_res = src_a ^ src_b;
            OP_NOR:  w_alu_res = ~(src_a | src_b);
`ifdef FAST_SHIFT_EN
            OP_SLL, OP_SLLV: w_alu_res = src_b << w_amt;
            OP_SRL, OP_SRLV: w_alu_res = src_b >> w_amt;
            OP_SRA, OP_SRAV: w_alu_res = $signed(src_b) >>> w_amt;
`else
            // Only the zero-amount case completes here; nonzero amounts iterate.
            OP_SLL, OP_SLLV, OP_SRL, OP_SRLV, OP_SRA, OP_SRAV: w_alu_res = src_b;
`endif
            default: w_alu_res = '0;
        endcase
    end

`ifndef FAST_SHIFT_EN
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic               r_arith;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_step;

    assign w_is_shift = (sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA) || w_var;
    assign w_step     = r_left ? {r_work[WIDTH-2:0], 1'b0}
                               : {r_arith & r_work[WIDTH-1], r_work[WIDTH-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
`ifndef FAST_SHIFT_EN
            r_work   <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_arith  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
`ifndef FAST_SHIFT_EN
                        if (w_is_shift && (w_amt != '0)) begin
                            r_work  <= src_b;
                            r_cnt   <= w_amt;
                            r_left  <= (sel == OP_SLL) || (sel == OP_SLLV);
                            r_arith <= (sel == OP_SRA) || (sel == OP_SRAV);
                            r_state <= S_SHIFT;
                        end else
`endif
                        begin
                            r_result <= w_alu_res;
                            r_zero   <= (w_alu_res == '0);
                            r_state  <= S_DONE;
                        end
                    end
                end
`ifndef FAST_SHIFT_EN
                S_SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result <= w_step;
                        r_zero   <= (w_step == '0);
                        r_state  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_SHIFT);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; expected latency/busy follow FAST_SHIFT_EN when defined.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_a(src_a), .src_b(src_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept edge.
    task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        chk("issue_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; sel = s; src_a = a; src_b = b; shamt = sh;
        step();
        in_valid = 1'b0; sel = 4'hx; src_a = 'x; src_b = 'x; shamt = 'x;
    endtask

    // Issue, wait (bounded) for out_valid, check latency, busy cycles, result and zero.
    task automatic run_op(input string tag, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] er, input int elat, input int ebusy);
        int lat;
        int bcnt;
        issue(s, a, b, sh);
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy"}, bcnt, ebusy);
        chk({tag, "_res"}, result, er);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        chk("consume_in_ready", {31'd0, in_ready}, 32'd1);
        chk("consume_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    function automatic int slat(input int n);
        return (FAST || n == 0) ? 1 : n + 1;
    endfunction

    function automatic int sbusy(input int n);
        return FAST ? 0 : n;
    endfunction

    initial begin
        bit ok;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; src_a = '0; src_b = '0; shamt = '0;
        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        rst_n = 1'b1;
        step();

        // Reset in the middle of a long shift.
        issue(4'b0101, 32'd0, 32'd1, 5'd20);
        step(); step(); step();
        chk("midop_busy", {31'd0, busy}, {31'd0, !FAST});
        rst_n = 1'b0;
        step();
        chk("midop_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midop_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midop_busy_rst", {31'd0, busy}, 32'd0);
        chk("midop_result", result, 32'd0);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid || busy) ok = 1'b0;
        end
        chk("midop_no_emit", {31'd0, ok}, 32'd1);

        out_ready = 1'b1;
        run_op("add", 4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1, 0);
        consume();
        run_op("sub", 4'b0011, 32'd5, 32'd5, 5'd0, 32'd0, 1, 0);
        consume();
        run_op("slt_neg", 4'b0100, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1, 0);
        consume();
        run_op("slt_swap", 4'b0100, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1, 0);
        consume();
        run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1, 0);
        consume();
        run_op("or", 4'b0001, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'hF000_0F01, 1, 0);
        consume();
        run_op("xor", 4'b1001, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 32'h5555_5555, 1, 0);
        consume();
        run_op("nor", 4'b1010, 32'd0, 32'h0000_00FF, 5'd0, 32'hFFFF_FF00, 1, 0);
        consume();

        run_op("sra31", 4'b0111, 32'd0, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, slat(31), sbusy(31));
        consume();
        run_op("srav0", 4'b1110, 32'hFFFF_FFE0, 32'h8765_4321, 5'd7, 32'h8765_4321, 1, 0);
        consume();
        run_op("sll31", 4'b0101, 32'd0, 32'd1, 5'd31, 32'h8000_0000, slat(31), sbusy(31));
        consume();
        run_op("srl4", 4'b0110, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, slat(4), sbusy(4));
        consume();
        run_op("sllv3", 4'b1100, 32'h0000_0023, 32'd1, 5'd0, 32'd8, slat(3), sbusy(3));
        consume();
        run_op("sll_out", 4'b0101, 32'd0, 32'h8000_0001, 5'd1, 32'd2, slat(1), sbusy(1));
        consume();

        // Backpressure: result held, no accept while the consumer stalls.
        out_ready = 1'b0;
        run_op("srlv_bp", 4'b1101, 32'd4, 32'h0000_00F0, 5'd0, 32'h0000_000F, slat(4), sbusy(4));
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; sel = 4'b0010; src_a = 32'd9; src_b = 32'd9;
            step();
            if (result !== 32'h0000_000F || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_hold", {31'd0, ok}, 32'd1);
        consume();
        run_op("after_bp", 4'b0010, 32'd40, 32'd2, 5'd0, 32'd42, 1, 0);
        consume();

        run_op("nop", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 1, 0);
        consume();
        run_op("undef1011", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 1, 0);
        consume();
        run_op("undef1000", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0, 1, 0);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU for the MIPS datapath; sits directly downstream of the ALU control decoder.
- Consumes the decoder's 4-bit sel code plus rs/rt operands and shamt, and produces a registered result and zero flag for writeback and branch compare.
- Logic ops and add/sub/slt complete in one cycle. Shifts are iterative, one bit per cycle, to save area.
- Valid/ready handshake on both sides so the pipeline can stall on multi-cycle shifts.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operation presented this cycle.
- in_ready  output  1  unit can accept an operation.
- sel  input  4  ALU control code: AND=0000, OR=0001, ADD=0010, SUB=0011, SLT=0100, SLL=0101, SRL=0110, SRA=0111, XOR=1001, NOR=1010, SLLV=1100, SRLV=1101, SRAV=1110, NOP=1111.
- src_a  input  WIDTH  rs operand; for SLLV/SRLV/SRAV only src_a[SHAMT_W-1:0] is used, as the shift amount.
- src_b  input  WIDTH  rt operand; this is the value shifted by all shift ops.
- shamt  input  SHAMT_W  shift amount for SLL/SRL/SRA.
- out_valid  output  1  result and zero are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered ALU result.
- zero  output  1  high when result == 0.
- busy  output  1  high while a shift iteration is in progress.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, in_ready=1 after reset, out_valid=0, result=0, zero=0, busy=0, shift counter=0.
- Reset overrides all other inputs, including mid-shift or while holding an unconsumed result. No partial result is emitted.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). busy = (state==SHIFT). out_valid = (state==DONE).
- Accept occurs when in_valid && in_ready at a clock edge. At accept, sel, src_a, src_b and the effective shift amount are captured. Inputs are don't-care at all other times.
- IDLE, non-shift op at accept: result is computed and registered, next state DONE. out_valid is asserted the cycle after accept (latency 1).
  - ADD/SUB: modulo 2^WIDTH, no overflow trap.
  - SLT: signed compare, result = {0..0, a<b}.
  - NOR = ~(a|b).
- NOP and undefined codes (1000, 1011): result=0, zero=1, latency 1.
- IDLE, shift op at accept: working register = src_b, counter = amount (shamt, or src_a[4:0] for V-variants).
  - Amount 0: result = src_b, next state DONE (latency 1).
  - Amount N>0: next state SHIFT.
- SHIFT, each cycle: shift working register by 1 bit and decrement counter.
  - SLL/SLLV: shift left, zero fill.
  - SRL/SRLV: shift right, zero fill.
  - SRA/SRAV: shift right, replicate MSB.
  - When counter reaches 1 the final shift is performed, result is loaded and next state is DONE.
  - Total latency from accept to out_valid = N+1 cycles. Maximum is 32 cycles for N=31.
- DONE: result and zero are held stable while out_ready=0.
  - out_valid && out_ready at an edge: next state IDLE.
  - No accept can occur in the same cycle as consume, because in_ready is low in DONE. Back-to-back throughput is therefore one op per 2 cycles minimum.
- zero is computed from the final registered result in every case.
- Inputs changing while in SHIFT or DONE have no effect.

Optional Feature:
- Macro FAST_SHIFT_EN.
- Defined: every shift op completes in a single cycle via a combinational barrel shifter. The SHIFT state is never entered, busy stays 0, and all ops have latency 1.
- Undefined (default): iterative shifter as described under Behaviour, latency N+1 for shifts.
- Results are bit-identical in both builds; only latency and busy differ.

Test Plan:
- Reset mid-op: start SLL, src_b=1, shamt=20; assert rst_n=0 on cycle 5 -> next cycle out_valid=0, in_ready=1, busy=0, result=0; no result emitted afterwards.
- ADD then SUB: ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, zero=0 after 1 cycle. SUB a=5, b=5 -> result 0, zero=1.
- SLT signed: a=0xFFFFFFFF (-1), b=1 -> result 1. Swapped operands -> result 0, zero=1.
- Iterative SRA: b=0x80000000, shamt=31 -> busy high for 31 cycles, out_valid on cycle 32, result 0xFFFFFFFF. SRAV with a[4:0]=0 -> result=b after 1 cycle.
- Backpressure: SRLV a=4, b=0xF0 with out_ready=0 for 10 cycles -> result 0x0F held stable, in_ready=0 throughout. Raise out_ready -> IDLE next cycle, next op accepted.
- NOP and undefined codes: sel=1111, then sel=1011, each with a=b=0xFFFFFFFF -> result 0, zero=1 after 1 cycle. With FAST_SHIFT_EN defined, SLL shamt=31 -> out_valid after 1 cycle, busy never asserted.
